// File: rtl/fl_hw_responder_mon.sv
// FrameLink sink for accelerated verification: LFSR-driven back-pressure, on-the-fly
// framing checks, frame/byte/length statistics and sticky error flags for software.
module fl_hw_responder_mon #(
    parameter int          DATA_WIDTH        = 64,
    parameter int          DREM_WIDTH        = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
    parameter int          MAX_FRAME_BYTES   = 16383,
    parameter logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [DREM_WIDTH-1:0] RX_DREM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SOP_N,
    input  logic                  RX_EOP_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,
    input  logic                  CFG_ENABLE,
    input  logic [7:0]            CFG_WAIT_THRESH,
    input  logic                  CFG_SEED_LOAD,
    input  logic [15:0]           CFG_SEED,
    input  logic                  ERR_CLR,
    output logic [31:0]           FRAME_CNT,
    output logic [47:0]           BYTE_CNT,
    output logic [15:0]           LAST_FRAME_LEN,
    output logic                  FRAME_DONE,
    output logic [5:0]            ERR,
    output logic [2:0]            ERR_FIRST,
    output logic [1:0]            DBG_STATE
);

    localparam int ACC_W = 17;
    localparam logic [ACC_W-1:0] ACC_SAT = '1;
    localparam logic [ACC_W-1:0] FULL_WORD_BYTES = ACC_W'(DATA_WIDTH / 8);

    // Debug encoding seen on DBG_STATE: 0 = IDLE, 1 = IN_PART, 2 = GAP.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IN_PART = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [ACC_W-1:0] frame_acc;
    logic             ovf_seen;

    logic             xfer, sof, eof, sop, eop;
    logic [ACC_W-1:0] word_bytes, acc_base, acc_next;
    logic [ACC_W:0]   acc_sum;
    logic             acc_over, ovf_prior;
    logic [5:0]       err_raw, err_set, err_base;
    logic [2:0]       first_idx;
    state_t           state_next;
    logic             unused_data;

    // Handshake: a word transfers on a rising CLK edge where RX_SRC_RDY_N and
    // RX_DST_RDY_N are both low; every other cycle leaves the FSM and counters alone.
    assign xfer = ~RX_SRC_RDY_N & ~RX_DST_RDY_N;
    assign sof  = ~RX_SOF_N;
    assign eof  = ~RX_EOF_N;
    assign sop  = ~RX_SOP_N;
    assign eop  = ~RX_EOP_N;

    assign unused_data = ^{RX_DATA, 1'b0};
    assign DBG_STATE   = state;

    always_comb begin
        word_bytes = RX_EOP_N ? FULL_WORD_BYTES
                              : {{(ACC_W-DREM_WIDTH){1'b0}}, RX_DREM} + 17'd1;
        // SOF restarts the frame length, so its own bytes start a fresh count.
        acc_base   = sof ? '0 : frame_acc;
        acc_sum    = {1'b0, acc_base} + {1'b0, word_bytes};
        acc_next   = acc_sum[ACC_W] ? ACC_SAT : acc_sum[ACC_W-1:0];
        acc_over   = acc_next > ACC_W'(MAX_FRAME_BYTES);
        ovf_prior  = sof ? 1'b0 : ovf_seen;

        err_raw    = '0;
        err_raw[0] = (sof & ~sop) | (eof & ~eop);
        err_raw[1] = sof & (state != ST_IDLE);
        err_raw[2] = ~sof & (state == ST_IDLE);
        err_raw[3] = sop & (state == ST_IN_PART);
        err_raw[4] = ~sop & (state == ST_GAP);
        err_raw[5] = acc_over & ~ovf_prior;
        err_set    = xfer ? err_raw : '0;
        err_base   = ERR_CLR ? '0 : ERR;

        first_idx = '0;
        for (int i = 5; i >= 0; i--) begin
            if (err_set[i]) first_idx = 3'(i);
        end

        if (eof)      state_next = ST_IDLE;
        else if (eop) state_next = ST_GAP;
        else          state_next = ST_IN_PART;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= ST_IDLE;
            lfsr           <= LFSR_SEED_DEFAULT;
            RX_DST_RDY_N   <= 1'b1;
            frame_acc      <= '0;
            ovf_seen       <= 1'b0;
            FRAME_CNT      <= '0;
            BYTE_CNT       <= '0;
            LAST_FRAME_LEN <= '0;
            FRAME_DONE     <= 1'b0;
            ERR            <= '0;
            ERR_FIRST      <= '0;
        end else begin
            RX_DST_RDY_N <= ~(CFG_ENABLE & (lfsr[7:0] >= CFG_WAIT_THRESH));
            if (CFG_SEED_LOAD)
                lfsr <= (CFG_SEED == 16'd0) ? 16'h0001 : CFG_SEED;
            else
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            FRAME_DONE <= xfer & eof;
            ERR        <= err_base | err_set;
            if ((err_base == 6'd0) && (err_set != 6'd0))
                ERR_FIRST <= first_idx;
            else if (ERR_CLR)
                ERR_FIRST <= 3'd0;

            if (xfer) begin
                state     <= state_next;
                frame_acc <= acc_next;
                ovf_seen  <= ovf_prior | acc_over;
                BYTE_CNT  <= BYTE_CNT + {31'd0, word_bytes};
                if (eof) begin
                    FRAME_CNT      <= FRAME_CNT + 32'd1;
                    LAST_FRAME_LEN <= acc_next[ACC_W-1] ? 16'hFFFF : acc_next[15:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_fl_hw_responder_mon.sv
// Bench for fl_hw_responder_mon: spec-level model compared every cycle, plus directed
// frames with hand-computed lengths, counts and error codes.
module tb_fl_hw_responder_mon;

    localparam int DW   = 64;
    localparam int BPW  = DW / 8;
    localparam int MAXB = 1024;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic [DW-1:0] RX_DATA = '0;
    logic [2:0]    RX_DREM = '0;
    logic          RX_SOF_N = 1'b1, RX_EOF_N = 1'b1, RX_SOP_N = 1'b1, RX_EOP_N = 1'b1;
    logic          RX_SRC_RDY_N = 1'b1;
    logic          RX_DST_RDY_N;
    logic          CFG_ENABLE = 1'b1;
    logic [7:0]    CFG_WAIT_THRESH = 8'd0;
    logic          CFG_SEED_LOAD = 1'b0;
    logic [15:0]   CFG_SEED = 16'd0;
    logic          ERR_CLR = 1'b0;
    logic [31:0]   FRAME_CNT;
    logic [47:0]   BYTE_CNT;
    logic [15:0]   LAST_FRAME_LEN;
    logic          FRAME_DONE;
    logic [5:0]    ERR;
    logic [2:0]    ERR_FIRST;
    logic [1:0]    DBG_STATE;

    fl_hw_responder_mon #(.DATA_WIDTH(DW), .MAX_FRAME_BYTES(MAXB)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_DREM(RX_DREM),
        .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N), .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N),
        .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
        .CFG_ENABLE(CFG_ENABLE), .CFG_WAIT_THRESH(CFG_WAIT_THRESH),
        .CFG_SEED_LOAD(CFG_SEED_LOAD), .CFG_SEED(CFG_SEED), .ERR_CLR(ERR_CLR),
        .FRAME_CNT(FRAME_CNT), .BYTE_CNT(BYTE_CNT), .LAST_FRAME_LEN(LAST_FRAME_LEN),
        .FRAME_DONE(FRAME_DONE), .ERR(ERR), .ERR_FIRST(ERR_FIRST), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int done_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model (spec rules, plain arithmetic) ----------------
    int          m_state;   // 0 idle, 1 inside a part, 2 between parts
    bit          m_rdy_n;
    logic [15:0] m_lfsr;
    longint      m_frame_cnt, m_byte_cnt, m_accepted;
    int          m_last_len, m_acc, m_first;
    bit          m_done, m_ovf_done;
    logic [5:0]  m_err, m_e;
    bit          m_take, m_sof, m_eof, m_sop, m_eop, m_next_rdy_n;
    int          m_nbytes;

    function automatic int lowest_set(input logic [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial forever begin
        @(posedge CLK or negedge RESET_N);
        if (!RESET_N) begin
            m_state = 0; m_rdy_n = 1'b1; m_lfsr = 16'hACE1;
            m_frame_cnt = 0; m_byte_cnt = 0; m_last_len = 0; m_acc = 0;
            m_first = 0; m_done = 1'b0; m_ovf_done = 1'b0; m_err = '0;
        end else begin
            m_take      = !RX_SRC_RDY_N && !m_rdy_n;
            m_next_rdy_n = !(CFG_ENABLE && (m_lfsr[7:0] >= CFG_WAIT_THRESH));
            if (CFG_SEED_LOAD) m_lfsr = (CFG_SEED == 0) ? 16'h0001 : CFG_SEED;
            else               m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            m_rdy_n = m_next_rdy_n;
            m_e = '0;
            m_done = 1'b0;
            if (m_take) begin
                m_sof = !RX_SOF_N; m_eof = !RX_EOF_N; m_sop = !RX_SOP_N; m_eop = !RX_EOP_N;
                m_nbytes = RX_EOP_N ? BPW : int'(RX_DREM) + 1;
                if ((m_sof && !m_sop) || (m_eof && !m_eop)) m_e[0] = 1'b1;
                if (m_sof && m_state != 0)  m_e[1] = 1'b1;
                if (!m_sof && m_state == 0) m_e[2] = 1'b1;
                if (m_sop && m_state == 1)  m_e[3] = 1'b1;
                if (!m_sop && m_state == 2) m_e[4] = 1'b1;
                if (m_sof) begin m_acc = 0; m_ovf_done = 1'b0; end
                m_acc += m_nbytes;
                if (m_acc > MAXB && !m_ovf_done) begin m_e[5] = 1'b1; m_ovf_done = 1'b1; end
                m_state = m_eof ? 0 : (m_eop ? 2 : 1);
                m_byte_cnt += m_nbytes;
                m_accepted++;
                if (m_eof) begin
                    m_frame_cnt++;
                    m_last_len = (m_acc > 65535) ? 65535 : m_acc;
                    m_done = 1'b1;
                end
            end
            if (ERR_CLR) begin
                m_err   = m_e;
                m_first = (m_e != 0) ? lowest_set(m_e) : 0;
            end else if (m_e != 0) begin
                if (m_err == 0) m_first = lowest_set(m_e);
                m_err = m_err | m_e;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("dst_rdy_n", 64'(RX_DST_RDY_N), 64'(m_rdy_n));
            chk("frame_cnt", 64'(FRAME_CNT), 64'(m_frame_cnt[31:0]));
            chk("byte_cnt", 64'(BYTE_CNT), 64'(m_byte_cnt[47:0]));
            chk("last_len", 64'(LAST_FRAME_LEN), 64'(m_last_len));
            chk("frame_done", 64'(FRAME_DONE), 64'(m_done));
            chk("err", 64'(ERR), 64'(m_err));
            chk("err_first", 64'(ERR_FIRST), 64'(m_first));
            chk("state", 64'(DBG_STATE), 64'(m_state));
        end
        if (FRAME_DONE === 1'b1) done_pulses++;
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        RX_SRC_RDY_N = 1'b1;
        RX_SOF_N = 1'b1; RX_EOF_N = 1'b1; RX_SOP_N = 1'b1; RX_EOP_N = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #2; end
    endtask

    task automatic do_reset();
        idle();
        ERR_CLR = 1'b0;
        CFG_SEED_LOAD = 1'b0;
        RESET_N = 1'b0;
        tick(2);
        RESET_N = 1'b1;
    endtask

    // Presents one word and holds it until the edge that accepts it.
    task automatic send_word(input bit sof, input bit eof, input bit sop, input bit eop,
                             input logic [2:0] drem);
        bit got;
        int n;
        RX_DATA = {$urandom, $urandom};
        RX_DREM = drem;
        RX_SOF_N = !sof; RX_EOF_N = !eof; RX_SOP_N = !sop; RX_EOP_N = !eop;
        RX_SRC_RDY_N = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge CLK);
            got = (RX_DST_RDY_N === 1'b0);
            @(posedge CLK);
            #2;
            n++;
        end
        if (!got) chk("send_timeout", 64'd0, 64'd1);
    endtask

    function automatic int ref_accepts(input logic [15:0] seed, input int n);
        logic [15:0] l;
        int c;
        l = seed;
        c = 0;
        for (int j = 1; j <= n; j++) begin
            l = {l[14:0], ^(l & 16'hB400)};
            if (l[7:0] >= 8'd128) c++;
        end
        return c;
    endfunction

    task automatic run_stream(input logic [15:0] seed, input int n);
        longint acc0;
        do_reset();
        acc0 = m_accepted;
        CFG_WAIT_THRESH = 8'd128;
        CFG_SEED = seed;
        CFG_SEED_LOAD = 1'b1;
        tick(1);
        CFG_SEED_LOAD = 1'b0;
        tick(2);
        for (int i = 0; i < n; i++) begin
            RX_DATA = {$urandom, $urandom};
            RX_DREM = 3'(i % 8);
            RX_SOF_N = 1'b0; RX_EOF_N = 1'b0; RX_SOP_N = 1'b0; RX_EOP_N = 1'b0;
            RX_SRC_RDY_N = 1'b0;
            tick(1);
        end
        idle();
        tick(2);
        chk("stream_frames_vs_ref", 64'(FRAME_CNT), 64'(ref_accepts((seed == 0) ? 16'h1 : seed, n)));
        chk("stream_model_vs_ref", 64'(m_accepted - acc0), 64'(ref_accepts((seed == 0) ? 16'h1 : seed, n)));
        chk("stream_bytes", 64'(BYTE_CNT), 64'(m_byte_cnt));
        CFG_WAIT_THRESH = 8'd0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        checks++;
        errors++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- directed tests ----------------
    initial begin
        m_accepted = 0;
        #3;
        RESET_N = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset_dst_rdy_n", 64'(RX_DST_RDY_N), 64'd1);
        chk("reset_err", 64'(ERR), 64'd0);
        tick(2);
        RESET_N = 1'b1;

        // Disabled: no acceptance, ready stays high; enabling makes it ready next cycle.
        CFG_ENABLE = 1'b0;
        do_reset();
        RX_SOF_N = 1'b0; RX_SOP_N = 1'b0; RX_EOF_N = 1'b0; RX_EOP_N = 1'b0;
        RX_SRC_RDY_N = 1'b0;
        tick(4);
        chk("dis_dst_rdy_n", 64'(RX_DST_RDY_N), 64'd1);
        chk("dis_frame_cnt", 64'(FRAME_CNT), 64'd0);
        idle();
        CFG_ENABLE = 1'b1;
        tick(1);
        chk("en_dst_rdy_n", 64'(RX_DST_RDY_N), 64'd0);

        // 3-word single-part frame, DREM=3 on last: 8+8+4 = 20 bytes.
        do_reset();
        chk("t1_rdy_before", 64'(RX_DST_RDY_N), 64'd1);
        done_pulses = 0;
        send_word(1, 0, 1, 0, 3'd0);
        send_word(0, 0, 0, 0, 3'd0);
        send_word(0, 1, 0, 1, 3'd3);
        idle();
        tick(3);
        chk("t1_last_len", 64'(LAST_FRAME_LEN), 64'd20);
        chk("t1_frame_cnt", 64'(FRAME_CNT), 64'd1);
        chk("t1_byte_cnt", 64'(BYTE_CNT), 64'd20);
        chk("t1_done_pulses", 64'(done_pulses), 64'd1);
        chk("t1_err", 64'(ERR), 64'd0);

        // Two-part frame: 8 + 8 + 1 = 17; then payload missing SOP.
        do_reset();
        send_word(1, 0, 1, 1, 3'd7);
        send_word(0, 0, 1, 0, 3'd0);
        send_word(0, 1, 0, 1, 3'd0);
        idle();
        tick(1);
        chk("t2_last_len", 64'(LAST_FRAME_LEN), 64'd17);
        chk("t2_err_clean", 64'(ERR), 64'd0);
        send_word(1, 0, 1, 1, 3'd7);
        send_word(0, 0, 0, 0, 3'd0);
        send_word(0, 1, 0, 1, 3'd0);
        idle();
        tick(1);
        chk("t2_err_gap", 64'(ERR), 64'b010000);
        chk("t2_err_first", 64'(ERR_FIRST), 64'd4);
        chk("t2_frame_cnt", 64'(FRAME_CNT), 64'd2);
        chk("t2_last_len2", 64'(LAST_FRAME_LEN), 64'd17);

        // SOF (with SOP) inside a part: ERR[1] and ERR[3]; new frame counted once.
        do_reset();
        send_word(1, 0, 1, 0, 3'd0);
        send_word(0, 0, 0, 0, 3'd0);
        send_word(1, 0, 1, 0, 3'd0);
        send_word(0, 0, 0, 0, 3'd0);
        chk("t3_err", 64'(ERR), 64'b001010);
        chk("t3_err_first", 64'(ERR_FIRST), 64'd1);
        chk("t3_cnt_before_eof", 64'(FRAME_CNT), 64'd0);
        send_word(0, 1, 0, 1, 3'd3);
        idle();
        tick(1);
        chk("t3_frame_cnt", 64'(FRAME_CNT), 64'd1);
        chk("t3_last_len", 64'(LAST_FRAME_LEN), 64'd20);

        // Random back-pressure against an independent LFSR count.
        run_stream(16'h0001, 1000);
        run_stream(16'h0000, 200);

        // 300-word frame: crosses 1024 bytes on word 129; 2400 bytes total.
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            send_word(i == 1, i == 300, i == 1, i == 300, 3'd7);
            if (i == 128) chk("t5_err_at_1024", 64'(ERR), 64'd0);
            if (i == 129) chk("t5_err_at_1032", 64'(ERR), 64'b100000);
        end
        idle();
        tick(1);
        chk("t5_last_len", 64'(LAST_FRAME_LEN), 64'd2400);
        chk("t5_err_first", 64'(ERR_FIRST), 64'd5);
        chk("t5_err_once", 64'(ERR), 64'b100000);

        // Reset mid-frame, then ERR_CLR together with a word lacking SOF.
        do_reset();
        send_word(1, 0, 1, 0, 3'd0);
        send_word(0, 0, 0, 0, 3'd0);
        idle();
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_rdy", 64'(RX_DST_RDY_N), 64'd1);
        chk("t6_rst_bytes", 64'(BYTE_CNT), 64'd0);
        chk("t6_rst_state", 64'(DBG_STATE), 64'd0);
        tick(2);
        RESET_N = 1'b1;
        ERR_CLR = 1'b1;
        send_word(0, 0, 0, 0, 3'd0);
        ERR_CLR = 1'b0;
        chk("t6_err", 64'(ERR), 64'b000100);
        chk("t6_err_first", 64'(ERR_FIRST), 64'd2);
        chk("t6_bytes", 64'(BYTE_CNT), 64'd8);

        // Plain clear, then accumulation with ERR_FIRST held.
        send_word(0, 1, 0, 1, 3'd1);
        idle();
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        chk("t7_clr_err", 64'(ERR), 64'd0);
        chk("t7_clr_first", 64'(ERR_FIRST), 64'd0);
        send_word(1, 1, 0, 1, 3'd0);
        chk("t7_err0", 64'(ERR), 64'b000001);
        send_word(0, 0, 1, 1, 3'd0);
        send_word(0, 0, 1, 0, 3'd0);
        send_word(1, 1, 1, 1, 3'd0);
        idle();
        tick(1);
        chk("t7_err_acc", 64'(ERR), 64'b001111);
        chk("t7_err_first", 64'(ERR_FIRST), 64'd0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fl_hw_responder_mon.md
Name: fl_hw_responder_mon

Overview:
- Synthesizable FrameLink sink for hardware-accelerated verification runs on the combo board.
- Replaces the software responder and monitor pair for one FL output of the DUT.
- Drives pseudo-random back-pressure and checks FL framing rules on the fly.
- Keeps frame, byte and length statistics, plus sticky error flags that software reads.

Parameters:
DATA_WIDTH, 64, FL data width in bits; power of two, 8..512
DREM_WIDTH, log2(DATA_WIDTH/8), width of RX_DREM; 1 when DATA_WIDTH=8
MAX_FRAME_BYTES, 16383, frame length above this sets ERR[5]
LFSR_SEED_DEFAULT, 16'hACE1, LFSR value loaded at reset

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
RX_DATA  in  DATA_WIDTH  FL data
RX_DREM  in  DREM_WIDTH  index of last valid byte; valid only on EOP word
RX_SOF_N  in  1  start of frame, active low
RX_EOF_N  in  1  end of frame, active low
RX_SOP_N  in  1  start of part, active low
RX_EOP_N  in  1  end of part, active low
RX_SRC_RDY_N  in  1  source ready, active low
RX_DST_RDY_N  out  1  destination ready, active low, registered
CFG_ENABLE  in  1  1 enables acceptance
CFG_WAIT_THRESH  in  8  back-pressure threshold; 0 means always ready
CFG_SEED_LOAD  in  1  pulse: load CFG_SEED into LFSR
CFG_SEED  in  16  LFSR seed; 0 is replaced by 16'h0001
ERR_CLR  in  1  pulse: clear ERR and ERR_FIRST
FRAME_CNT  out  32  accepted frames, wraps
BYTE_CNT  out  48  accepted payload bytes, wraps
LAST_FRAME_LEN  out  16  byte length of last completed frame, saturates 16'hFFFF
FRAME_DONE  out  1  one-cycle pulse after EOF accepted
ERR  out  6  sticky protocol error flags
ERR_FIRST  out  3  index of the first ERR bit set since the last clear

Behaviour:
- Reset values: RX_DST_RDY_N=1; all counters, LAST_FRAME_LEN, FRAME_DONE, ERR and ERR_FIRST =0; LFSR=LFSR_SEED_DEFAULT; FSM=IDLE.
- Transfer occurs when RX_SRC_RDY_N=0 and RX_DST_RDY_N=0. All other cycles are ignored by the FSM and counters.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
  - CFG_SEED_LOAD takes priority over advance.
- Next RX_DST_RDY_N = NOT(CFG_ENABLE AND lfsr[7:0] >= CFG_WAIT_THRESH).
  - CFG_WAIT_THRESH=0 with CFG_ENABLE=1 gives permanent ready from the next cycle.
  - CFG_ENABLE=0 deasserts ready on the next cycle.
- FSM states:
  - IDLE: expect a word with SOF and SOP.
  - IN_PART: inside a part.
  - GAP: between parts, expect SOP.
- FSM transitions on each transfer:
  - A word carrying SOF enters the frame: the frame byte accumulator is restarted.
  - A word carrying EOP goes to GAP; a word carrying EOF goes to IDLE; both evaluated after the SOF handling.
  - Any other word goes to or stays in IN_PART.
- Resync rule: every error still applies the word's flags as above, so the FSM always follows the incoming flags.
- Error bits (set on the transfer cycle, visible the next cycle):
  - [0] SOF without SOP, or EOF without EOP.
  - [1] SOF while in IN_PART or GAP.
  - [2] word in IDLE without SOF.
  - [3] SOP while in IN_PART.
  - [4] word in GAP without SOP.
  - [5] frame bytes > MAX_FRAME_BYTES; set at most once per frame.
- Word byte count: DATA_WIDTH/8 if EOP_N=1, else DREM+1. Counted for data bytes of every part; header and footer parts are not distinguished.
- Frame length and counters:
  - BYTE_CNT adds the word byte count on each transfer.
  - The frame accumulator is 17 bits saturating.
  - On EOF: FRAME_CNT+1, LAST_FRAME_LEN=min(acc, 16'hFFFF), and FRAME_DONE=1 for the following cycle.
- Latency: statistics and ERR reflect a transfer one cycle after it.
- ERR_FIRST is loaded only when ERR is all zero and at least one bit sets this cycle. If several bits set together, the lowest index wins.
- ERR_CLR in the same cycle as a new error: the new error wins. ERR holds only the new bits, and ERR_FIRST is set from them.
- SOF+EOF on one word (single-word frame) is legal: FSM IDLE→IDLE, and FRAME_DONE pulses.
- Asynchronous reset mid-frame returns every register to its reset value immediately. The first post-reset word without SOF sets ERR[2].

Test Plan:
- THRESH=0, ENABLE=1, DATA_WIDTH=64: 3-word single-part frame, DREM=3 on last → RX_DST_RDY_N=0 from 2nd cycle; LAST_FRAME_LEN=20; FRAME_CNT=1; BYTE_CNT=20; FRAME_DONE one pulse; ERR=0.
- Two-part frame (header 1 word DREM=7, payload 2 words DREM=0) → LAST_FRAME_LEN=17, ERR=0; then the same frame with SOP missing on the payload → ERR=6'b010000, ERR_FIRST=4.
- SOF mid-part → ERR[1]=1; the new frame is still counted; FRAME_CNT increments once, at the new frame's EOF.
- THRESH=128, seed 16'h0001, 1000 cycles of continuous SRC_RDY → accepted words equal the reference LFSR model count exactly; no word lost or duplicated (checked via BYTE_CNT).
- 300-word frame with MAX_FRAME_BYTES=1024 → ERR[5] sets on the word crossing 1024 bytes; LAST_FRAME_LEN=2400.
- Reset asserted mid-frame, then ERR_CLR pulsed together with an IDLE word lacking SOF → ERR=6'b000100, ERR_FIRST=2.
